// File: rtl/sram_like_arbiter.sv
// Round-robin arbiter merging NCH sram-like masters onto one slave, with an in-order ID FIFO for data returns.
// Optional arbitration-stall counter enabled by defining ARB_STALL_CNT_EN.
module sram_like_arbiter #(
   parameter int NCH     = 2,
   parameter int MAX_OUT = 4,
   parameter int DATA_W  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NCH-1:0]        m_req,
   input  logic [NCH-1:0]        m_wr,
   input  logic [2*NCH-1:0]      m_size,
   input  logic [DATA_W*NCH-1:0] m_addr,
   input  logic [DATA_W*NCH-1:0] m_wdata,
   output logic [NCH-1:0]        m_addrok,
   output logic [NCH-1:0]        m_dataok,
   output logic [DATA_W-1:0]     m_rdata,
   output logic                  s_req,
   output logic                  s_wr,
   output logic [1:0]            s_size,
   output logic [DATA_W-1:0]     s_addr,
   output logic [DATA_W-1:0]     s_wdata,
   input  logic [DATA_W-1:0]     s_rdata,
   input  logic                  s_addrok,
   input  logic                  s_dataok,
   output logic                  err,
   output logic [31:0]           stall_cnt
);

   localparam int ID_W  = $clog2(NCH);
   localparam int PTR_W = $clog2(MAX_OUT);
   localparam int CNT_W = $clog2(MAX_OUT + 1);

   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic             lock_q, lock_d;
   logic [ID_W-1:0]  lock_ch_q, lock_ch_d;
   logic             err_q, err_d;
   logic [ID_W-1:0]  fifo_mem_q [MAX_OUT];
   logic [ID_W-1:0]  fifo_mem_d [MAX_OUT];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic            any_req;
   logic            fifo_full;
   logic            fifo_empty;
   logic            handshake;
   logic            pop;
   logic            found;
   logic [ID_W-1:0] grant;
   logic [ID_W-1:0] head;

   assign any_req    = |m_req;
   assign fifo_full  = (count_q == CNT_W'(MAX_OUT));
   assign fifo_empty = (count_q == '0);
   assign head       = fifo_mem_q[rd_ptr_q];
   assign m_rdata    = s_rdata;
   assign err        = err_q;

   // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      grant = rr_ptr_q;
      found = 1'b0;
      if (lock_q) begin
         grant = lock_ch_q;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (!found && m_req[(int'(rr_ptr_q) + i) % NCH]) begin
               grant = ID_W'((int'(rr_ptr_q) + i) % NCH);
               found = 1'b1;
            end
         end
      end
   end

   // A full FIFO blocks new requests even when a pop frees a slot this same cycle.
   assign s_req     = any_req && !fifo_full;
   assign s_wr      = m_wr[grant];
   assign s_size    = m_size[2*grant +: 2];
   assign s_addr    = m_addr[grant*DATA_W +: DATA_W];
   assign s_wdata   = m_wdata[grant*DATA_W +: DATA_W];
   assign handshake = s_req && s_addrok;
   assign pop       = s_dataok && !fifo_empty;

   always_comb begin
      m_addrok        = '0;
      m_addrok[grant] = handshake;
      m_dataok        = '0;
      if (pop) begin
         m_dataok[head] = 1'b1;
      end
   end

   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      lock_d     = lock_q;
      lock_ch_d  = lock_ch_q;
      err_d      = err_q;
      fifo_mem_d = fifo_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;

      if (handshake) begin
         lock_d   = 1'b0;
         rr_ptr_d = (int'(grant) == NCH - 1) ? '0 : grant + ID_W'(1);
         fifo_mem_d[wr_ptr_q] = grant;
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else if (s_req) begin
         lock_d    = 1'b1;
         lock_ch_d = grant;
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      if (handshake && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !handshake) begin
         count_d = count_q - CNT_W'(1);
      end

      // Protocol violations: stray data return, or the locked master withdrawing its request.
      if ((s_dataok && fifo_empty) || (lock_q && !m_req[lock_ch_q])) begin
         err_d = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q  <= '0;
         lock_q    <= 1'b0;
         lock_ch_q <= '0;
         err_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         lock_q    <= lock_d;
         lock_ch_q <= lock_ch_d;
         err_q     <= err_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   // NOTE: the ID storage is not reset; entries are only read below count_q, which reset clears.
   always_ff @(posedge clk) begin
      fifo_mem_q <= fifo_mem_d;
   end

`ifdef ARB_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (any_req && !handshake && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: a model round-robin pointer predicts grants and a
// scoreboard queue of granted channel ids predicts which m_dataok bit each data return raises.
module tb_sram_like_arbiter;

   localparam int NCH     = 2;
   localparam int MAX_OUT = 4;
   localparam int DATA_W  = 32;

   localparam logic [DATA_W-1:0] ADDR0  = 32'h0000_1000;
   localparam logic [DATA_W-1:0] ADDR1  = 32'h0000_2000;
   localparam logic [DATA_W-1:0] WDATA0 = 32'hAAAA_0000;
   localparam logic [DATA_W-1:0] WDATA1 = 32'hBBBB_0001;

   logic                  clk;
   logic                  reset;
   logic [NCH-1:0]        m_req;
   logic [NCH-1:0]        m_wr;
   logic [2*NCH-1:0]      m_size;
   logic [DATA_W*NCH-1:0] m_addr;
   logic [DATA_W*NCH-1:0] m_wdata;
   logic [NCH-1:0]        m_addrok;
   logic [NCH-1:0]        m_dataok;
   logic [DATA_W-1:0]     m_rdata;
   logic                  s_req;
   logic                  s_wr;
   logic [1:0]            s_size;
   logic [DATA_W-1:0]     s_addr;
   logic [DATA_W-1:0]     s_wdata;
   logic [DATA_W-1:0]     s_rdata;
   logic                  s_addrok;
   logic                  s_dataok;
   logic                  err;
   logic [31:0]           stall_cnt;

   int total = 0;
   int bad   = 0;
   int rr    = 0;
   int sb [$];

   sram_like_arbiter #(.NCH(NCH), .MAX_OUT(MAX_OUT), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .m_req     (m_req),
      .m_wr      (m_wr),
      .m_size    (m_size),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_addrok  (m_addrok),
      .m_dataok  (m_dataok),
      .m_rdata   (m_rdata),
      .s_req     (s_req),
      .s_wr      (s_wr),
      .s_size    (s_size),
      .s_addr    (s_addr),
      .s_wdata   (s_wdata),
      .s_rdata   (s_rdata),
      .s_addrok  (s_addrok),
      .s_dataok  (s_dataok),
      .err       (err),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   function automatic int exp_grant(input logic [NCH-1:0] req, input int ptr);
      for (int i = 0; i < NCH; i++) begin
         if (req[(ptr + i) % NCH]) return (ptr + i) % NCH;
      end
      return ptr;
   endfunction

   function automatic logic [NCH-1:0] onehot(input int id);
      logic [NCH-1:0] v;
      v = '0;
      v[id] = 1'b1;
      return v;
   endfunction

   function automatic logic [DATA_W-1:0] addr_of(input int id);
      return (id == 0) ? ADDR0 : ADDR1;
   endfunction

   task automatic idle_inputs();
      m_req    = '0;
      s_addrok = 1'b0;
      s_dataok = 1'b0;
      s_rdata  = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      step();
      reset = 1'b0;
      sb.delete();
      rr = 0;
   endtask

   // Drive one data return and compare the raised m_dataok bit with the scoreboard head.
   task automatic data_return(input string tag, input logic [DATA_W-1:0] rdata);
      int e;
      s_dataok = 1'b1;
      s_rdata  = rdata;
      settle();
      e = (sb.size() > 0) ? sb.pop_front() : 0;
      check(tag, m_dataok, onehot(e));
      check({tag, "_rdata"}, m_rdata, rdata);
      step();
      s_dataok = 1'b0;
   endtask

   initial begin
      int g;
      int e;
      reset    = 1'b1;
      m_wr     = 2'b01;
      m_size   = 4'b01_10;
      m_addr   = {ADDR1, ADDR0};
      m_wdata  = {WDATA1, WDATA0};
      idle_inputs();
      step();
      step();

      // Combinational request path stays live while reset is held.
      m_req = 2'b01;
      settle();
      check("rst_sreq_live", s_req, 1'b1);
      check("rst_dataok", m_dataok, 2'b00);
      step();
      reset = 1'b0;
      m_req = 2'b00;
      settle();
      check("rst_err", err, 1'b0);
      check("rst_stall", stall_cnt, 32'd0);
      check("rst_sreq", s_req, 1'b0);
      check("rst_addrok", m_addrok, 2'b00);

      // Both masters requesting, slave always ready: alternating grants until the FIFO fills.
      for (int k = 0; k < 4; k++) begin
         m_req    = 2'b11;
         s_addrok = 1'b1;
         settle();
         g = exp_grant(m_req, rr);
         check("rr_grant_id", g, k % 2);
         check("rr_addrok", m_addrok, onehot(g));
         check("rr_saddr", s_addr, addr_of(g));
         check("rr_swr", s_wr, m_wr[g]);
         check("rr_ssize", s_size, m_size[2*g +: 2]);
         check("rr_swdata", s_wdata, (g == 0) ? WDATA0 : WDATA1);
         sb.push_back(g);
         rr = (g + 1) % NCH;
         step();
      end

      // FIFO full: request blocked, a pop the same cycle does not unblock it.
      settle();
      check("full_sreq", s_req, 1'b0);
      check("full_addrok", m_addrok, 2'b00);
      s_dataok = 1'b1;
      s_rdata  = 32'hA5A5_0001;
      settle();
      e = sb.pop_front();
      check("full_pop_dataok", m_dataok, onehot(e));
      check("full_pop_sreq", s_req, 1'b0);
      step();
      s_dataok = 1'b0;
      settle();
      check("after_pop_sreq", s_req, 1'b1);
      g = exp_grant(m_req, rr);
      check("after_pop_addrok", m_addrok, onehot(g));
      sb.push_back(g);
      rr = (g + 1) % NCH;
      step();

      m_req    = 2'b00;
      s_addrok = 1'b0;
      for (int k = 0; k < 4; k++) begin
         data_return("drain_dataok", 32'h1000_0000 + k);
      end
      settle();
      check("drained_sreq_idle", s_req, 1'b0);

      // Simultaneous push and pop.
      m_req    = 2'b01;
      s_addrok = 1'b1;
      settle();
      g = exp_grant(m_req, rr);
      check("sim_push0_addrok", m_addrok, onehot(g));
      sb.push_back(g);
      rr = (g + 1) % NCH;
      step();
      m_req    = 2'b10;
      s_dataok = 1'b1;
      s_rdata  = 32'h0000_BEEF;
      settle();
      g = exp_grant(m_req, rr);
      check("sim_push1_addrok", m_addrok, onehot(g));
      e = sb.pop_front();
      check("sim_pop_dataok", m_dataok, onehot(e));
      sb.push_back(g);
      rr = (g + 1) % NCH;
      step();
      m_req    = 2'b00;
      s_addrok = 1'b0;
      s_dataok = 1'b0;
      data_return("sim_last_dataok", 32'h0000_CAFE);

      // Lock: channel 1 stalled by the slave keeps the grant after channel 0 joins.
      m_req    = 2'b10;
      s_addrok = 1'b0;
      settle();
      check("lock_c1_saddr", s_addr, ADDR1);
      check("lock_c1_sreq", s_req, 1'b1);
      check("lock_c1_addrok", m_addrok, 2'b00);
      step();
      m_req = 2'b11;
      settle();
      check("lock_c2_saddr", s_addr, ADDR1);
      check("lock_c2_addrok", m_addrok, 2'b00);
      step();
      settle();
      check("lock_c3_saddr", s_addr, ADDR1);
      step();
      s_addrok = 1'b1;
      settle();
      check("lock_c4_addrok", m_addrok, 2'b10);
      check("lock_c4_saddr", s_addr, ADDR1);
      sb.push_back(1);
      rr = 0;
      step();
      settle();
      g = exp_grant(m_req, rr);
      check("unlock_saddr", s_addr, addr_of(g));
      check("unlock_addrok", m_addrok, onehot(g));
      sb.push_back(g);
      rr = (g + 1) % NCH;
      step();
      m_req    = 2'b00;
      s_addrok = 1'b0;
      data_return("lock_drain0", 32'h2222_0000);
      data_return("lock_drain1", 32'h2222_0001);
      check("no_err_yet", err, 1'b0);

      // Locked channel withdrawing its request is a protocol error; lock persists.
      m_req = 2'b01;
      settle();
      step();
      m_req = 2'b00;
      settle();
      check("drop_err_pre", err, 1'b0);
      step();
      check("drop_err_set", err, 1'b1);
      m_req = 2'b10;
      settle();
      check("drop_lock_saddr", s_addr, ADDR0);
      do_reset();
      settle();
      check("reset_clears_err", err, 1'b0);
      check("reset_sreq", s_req, 1'b0);

      // Stray data return with nothing outstanding.
      s_dataok = 1'b1;
      s_rdata  = 32'hDEAD_BEEF;
      settle();
      check("stray_dataok", m_dataok, 2'b00);
      check("stray_rdata", m_rdata, 32'hDEAD_BEEF);
      check("stray_err_pre", err, 1'b0);
      step();
      s_dataok = 1'b0;
      settle();
      check("stray_err_set", err, 1'b1);
      step();
      step();
      check("stray_err_held", err, 1'b1);

      // Reset with two outstanding ids discards them.
      do_reset();
      m_req    = 2'b01;
      s_addrok = 1'b1;
      settle();
      step();
      step();
      reset    = 1'b1;
      m_req    = 2'b00;
      s_addrok = 1'b0;
      step();
      reset    = 1'b0;
      s_dataok = 1'b1;
      s_rdata  = 32'h3333_3333;
      settle();
      check("midrst_dataok", m_dataok, 2'b00);
      check("midrst_err_pre", err, 1'b0);
      step();
      s_dataok = 1'b0;
      check("midrst_err_set", err, 1'b1);

      // Stall counter: five cycles of an unanswered request.
      do_reset();
      m_req    = 2'b01;
      s_addrok = 1'b0;
      for (int k = 0; k < 5; k++) step();
`ifdef ARB_STALL_CNT_EN
      check("stall_cnt_5", stall_cnt, 32'd5);
`else
      check("stall_cnt_off", stall_cnt, 32'd0);
`endif
      check("stall_no_err", err, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 2, number of sram-like master channels (2..8).
REQ-002 SHALL have parameter MAX_OUT, default 4, maximum outstanding accepted requests (power of 2, 2..16).
REQ-003 SHALL have parameter DATA_W, default 32, address and data width.
REQ-004 SHALL have port clk  in  1  sole clock; all state on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous active-high reset.
REQ-006 SHALL have ports m_req, m_wr  in  NCH each  per-channel request and write flag.
REQ-007 SHALL have port m_size  in  2*NCH  per-channel size, channel i at bits [2i+1:2i].
REQ-008 SHALL have ports m_addr, m_wdata  in  DATA_W*NCH each  per-channel address and write data, channel i in slice i.
REQ-009 SHALL have ports m_addrok, m_dataok  out  NCH each  per-channel handshake returns.
REQ-010 SHALL have port m_rdata  out  DATA_W  read data, broadcast to all channels.
REQ-011 SHALL have ports s_req, s_wr  out  1 each, s_size  out  2, s_addr, s_wdata  out  DATA_W each  slave request.
REQ-012 SHALL have ports s_rdata  in  DATA_W, s_addrok  in  1, s_dataok  in  1  slave returns.
REQ-013 SHALL have port err  out  1  sticky protocol-error flag.
REQ-014 SHALL have port stall_cnt  out  32  arbitration-stall counter (see Configuration).

Function
REQ-015 SHALL grant one channel per cycle by round robin: search starts at rr_ptr, lowest index after wrap wins.
REQ-016 SHALL drive s_req = (any m_req) AND NOT fifo_full; s_wr/s_size/s_addr/s_wdata SHALL mux combinationally from the granted channel.
REQ-017 SHALL lock the grant (lock=1, lock_ch=grant) when s_req=1 and s_addrok=0; while locked, grant SHALL be lock_ch regardless of other requests.
REQ-018 SHALL clear lock on the cycle s_req and s_addrok are both 1.
REQ-019 SHALL assert m_addrok[grant] = s_addrok AND s_req, combinationally, zero-cycle latency; other m_addrok bits 0.
REQ-020 SHALL on each address handshake push grant id into the ID FIFO and set rr_ptr = (grant+1) mod NCH.
REQ-021 SHALL pop the FIFO head on s_dataok and assert m_dataok[head] that same cycle; m_rdata = s_rdata always.
REQ-022 fifo_full (count==MAX_OUT) SHALL force s_req=0, even if a pop occurs that cycle.
REQ-023 Simultaneous push and pop when not full SHALL leave count unchanged, pointers both advance, wrap modulo MAX_OUT.
REQ-024 s_dataok with FIFO empty SHALL be ignored (no pop, all m_dataok 0) and SHALL set err, held until reset.
REQ-025 A channel dropping m_req while locked SHALL set err; lock SHALL remain until s_addrok.

Reset
REQ-026 On reset=1 at a clock edge: FIFO empty, count 0, rr_ptr 0, lock 0, err 0, stall_cnt 0.
REQ-027 Reset mid-transaction SHALL discard all outstanding IDs; later s_dataok before a new push SHALL set err.
REQ-028 During reset, s_req and all m_addrok/m_dataok SHALL still follow combinational rules on the reset state (s_req from m_req, FIFO empty).

Configuration
REQ-029 Macro ARB_STALL_CNT_EN defined: stall_cnt SHALL increment (saturating at 32'hFFFFFFFF) every cycle with any m_req=1 and no address handshake.
REQ-030 Macro ARB_STALL_CNT_EN undefined: stall_cnt SHALL be constant 0 and the counter register SHALL not exist.

Verification
REQ-031 NCH=2, m_req=2'b11 held, s_addrok=1 every cycle -> grants 0,1,0,1; rr_ptr alternates; FIFO ids 0,1,0,1.
REQ-032 m_req[1]=1, s_addrok=0 for 3 cycles, m_req[0] rises cycle 2 -> s_addr stays channel 1 address; m_addrok=2'b10 on cycle 4 when s_addrok=1.
REQ-033 MAX_OUT=4, 4 handshakes, no dataok -> s_req=0 on 5th request; one s_dataok -> s_req=1 next cycle, m_dataok to first-pushed channel.
REQ-034 s_dataok=1, s_rdata=32'hDEADBEEF while FIFO empty -> m_dataok=0, err=1 next cycle and held.
REQ-035 With ARB_STALL_CNT_EN, m_req=1 for 5 cycles, s_addrok=0 -> stall_cnt=5; without it stall_cnt=0.
REQ-036 Reset asserted with 2 outstanding, then s_dataok -> no m_dataok, err=1.
